// File: rtl/dram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dram_wr_arbiter
//  Purpose  : Arbitrates the port-B write path of two accelerator data RAMs
//             between the core writeback path (fixed priority, never
//             stalled) and a FIFO-buffered host preload interface. A
//             starvation counter requests a core hold when host data waits
//             too long.
//  Revision : 1.0  initial release
// ============================================================================
module dram_wr_arbiter #(
    parameter int DATA_W       = 128,
    parameter int AW0          = 14,
    parameter int AW1          = 17,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              in_clk,
    input  logic              in_reset,
    input  logic              in_core_we,
    input  logic [31:0]       in_core_addr,
    input  logic [DATA_W-1:0] in_core_data,
    input  logic              in_h_valid,
    output logic              out_h_ready,
    input  logic [31:0]       in_h_addr,
    input  logic [DATA_W-1:0] in_h_data,
    output logic              out_hold_req,
    input  logic              in_hold_ack,
    output logic              out_we0,
    output logic              out_we1,
    output logic [AW0-1:0]    out_addr0,
    output logic [AW1-1:0]    out_addr1,
    output logic [DATA_W-1:0] out_wdata,
    output logic              out_idle,
    output logic              out_err
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] C_LIMIT = WAIT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // FIFO storage and bookkeeping
    logic [31:0]       r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_h_ready;
    logic              r_pop_d;
    logic              r_idle;
    logic              r_err;
    state_t            r_state;
    state_t            w_state_next;

    logic              r_we0;
    logic              r_we1;
    logic [AW0-1:0]    r_addr0;
    logic [AW1-1:0]    r_addr1;
    logic [DATA_W-1:0] r_wdata;

    logic              w_push;
    logic              w_pop;
    logic              w_gnt;
    logic [31:0]       w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [CNT_W-1:0]  w_count_next;
    logic              w_unused;

    // Core always wins; host head is popped only when the core is silent.
    assign w_push       = in_h_valid & r_h_ready;
    assign w_pop        = ~in_core_we & (r_count != '0);
    assign w_gnt        = in_core_we | w_pop;
    assign w_sel_addr   = in_core_we ? in_core_addr : r_fifo_addr[r_rd_ptr];
    assign w_sel_data   = in_core_we ? in_core_data : r_fifo_data[r_rd_ptr];
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Address bits beyond the widest word index and the byte offset are ignored.
    assign w_unused = ^{w_sel_addr[30:AW1+4], w_sel_addr[3:0]};

    // FIFO payload storage, written on accepted push (no reset needed)
    always_ff @(posedge in_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= in_h_addr;
            r_fifo_data[r_wr_ptr] <= in_h_data;
        end
    end

    // FIFO pointers, occupancy, registered ready and starvation counter
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_h_ready <= 1'b1;
            r_wait    <= '0;
            r_pop_d   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count   <= w_count_next;
            r_h_ready <= (w_count_next < C_DEPTH);
            r_pop_d   <= w_pop;
            if (w_pop || (r_count == '0))
                r_wait <= '0;
            else if (r_wait != C_LIMIT)
                r_wait <= r_wait + WAIT_W'(1);
        end
    end

    // Port-B write registers: one-cycle latency from grant to RAM
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            r_we0   <= 1'b0;
            r_we1   <= 1'b0;
            r_addr0 <= '0;
            r_addr1 <= '0;
            r_wdata <= '0;
        end else begin
            r_we0 <= w_gnt & ~w_sel_addr[31];
            r_we1 <= w_gnt &  w_sel_addr[31];
            if (w_gnt) begin
                r_addr0 <= w_sel_addr[AW0+3:4];
                r_addr1 <= w_sel_addr[AW1+3:4];
                r_wdata <= w_sel_data;
            end
        end
    end

    // Hold FSM state register plus registered idle and sticky error flags
    always_ff @(posedge in_clk) begin
        if (!in_reset) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idle  <= (w_count_next == '0) && (w_state_next == S_IDLE);
            r_err   <= r_err | (in_core_we & in_hold_ack);
        end
    end

    // Hold FSM next state: request on saturation, release after a host pop lands
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (r_wait == C_LIMIT) w_state_next = S_REQ;
            S_REQ:   if (r_pop_d)           w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign out_h_ready  = r_h_ready;
    assign out_hold_req = (r_state == S_REQ);
    assign out_we0      = r_we0;
    assign out_we1      = r_we1;
    assign out_addr0    = r_addr0;
    assign out_addr1    = r_addr1;
    assign out_wdata    = r_wdata;
    assign out_idle     = r_idle;
    assign out_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_wr_arbiter
//  Purpose  : Directed self-checking bench for dram_wr_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dram_wr_arbiter;

    localparam int DATA_W = 128;
    localparam int AW0    = 14;
    localparam int AW1    = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              core_we;
    logic [31:0]       core_addr;
    logic [DATA_W-1:0] core_data;
    logic              h_valid;
    logic              h_ready;
    logic [31:0]       h_addr;
    logic [DATA_W-1:0] h_data;
    logic              hold_req;
    logic              hold_ack;
    logic              we0;
    logic              we1;
    logic [AW0-1:0]    addr0;
    logic [AW1-1:0]    addr1;
    logic [DATA_W-1:0] wdata;
    logic              idle;
    logic              err;

    int n_vec  = 0;
    int n_fail = 0;

    localparam logic [DATA_W-1:0] D_A  = {4{32'hAAAA_0001}};
    localparam logic [DATA_W-1:0] D_B  = {4{32'hBBBB_0002}};
    localparam logic [DATA_W-1:0] D_C  = {4{32'hCCCC_0003}};
    localparam logic [DATA_W-1:0] D_D  = {4{32'hDDDD_0004}};
    localparam logic [DATA_W-1:0] D_E  = {4{32'hEEEE_0005}};
    localparam logic [DATA_W-1:0] D_T  = {4{32'h1234_5678}};
    localparam logic [DATA_W-1:0] H0   = {4{32'h0000_F000}};
    localparam logic [DATA_W-1:0] H1   = {4{32'h1111_F001}};
    localparam logic [DATA_W-1:0] H2   = {4{32'h2222_F002}};
    localparam logic [DATA_W-1:0] H3   = {4{32'h3333_F003}};
    localparam logic [DATA_W-1:0] H4   = {4{32'h4444_F004}};
    localparam logic [DATA_W-1:0] H5   = {4{32'h5555_F005}};

    dram_wr_arbiter #(
        .DATA_W(DATA_W), .AW0(AW0), .AW1(AW1), .FIFO_DEPTH(4), .STARVE_LIMIT(16)
    ) dut (
        .in_clk       (clk),
        .in_reset     (rst_n),
        .in_core_we   (core_we),
        .in_core_addr (core_addr),
        .in_core_data (core_data),
        .in_h_valid   (h_valid),
        .out_h_ready  (h_ready),
        .in_h_addr    (h_addr),
        .in_h_data    (h_data),
        .out_hold_req (hold_req),
        .in_hold_ack  (hold_ack),
        .out_we0      (we0),
        .out_we1      (we1),
        .out_addr0    (addr0),
        .out_addr1    (addr1),
        .out_wdata    (wdata),
        .out_idle     (idle),
        .out_err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; core_we = 1'b0; core_addr = '0; core_data = '0;
        h_valid = 1'b0; h_addr = '0; h_data = '0; hold_ack = 1'b0;

        // ---- reset state
        tick(); tick();
        chk("rst_we0",   we0, 0);
        chk("rst_we1",   we1, 0);
        chk("rst_ready", h_ready, 1);
        chk("rst_idle",  idle, 1);
        chk("rst_hold",  hold_req, 0);
        chk("rst_err",   err, 0);
        chk("rst_addr0", addr0, 0);
        chk("rst_wdata", wdata, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_we0", we0, 0);

        // ---- core-only writes
        core_we = 1'b1; core_addr = 32'h0000_0040; core_data = D_A;
        tick();
        chk("core0_we0",   we0, 1);
        chk("core0_we1",   we1, 0);
        chk("core0_addr0", addr0, 4);
        chk("core0_wdata", wdata, D_A);
        core_addr = 32'h8000_0100; core_data = D_B;
        tick();
        chk("core1_we1",   we1, 1);
        chk("core1_we0",   we0, 0);
        chk("core1_addr1", addr1, 16);
        chk("core1_wdata", wdata, D_B);
        // word index beyond address width is truncated
        core_addr = 32'h7FFF_FFF0; core_data = D_T;
        tick();
        chk("trunc_we0",   we0, 1);
        chk("trunc_addr0", addr0, 14'h3FFF);
        chk("trunc_addr1", addr1, 17'h1FFFF);
        core_we = 1'b0;
        tick();
        chk("nogrant_we0",   we0, 0);
        chk("nogrant_we1",   we1, 0);
        chk("nogrant_wdata", wdata, D_T);
        chk("nogrant_addr0", addr0, 14'h3FFF);
        chk("nogrant_idle",  idle, 1);

        // ---- host fill while core writes every cycle
        core_we = 1'b1; core_addr = 32'h0000_0010; core_data = D_C;
        h_valid = 1'b1;
        h_addr = 32'h0000_0100; h_data = H0; tick();
        chk("fill1_ready", h_ready, 1);
        h_addr = 32'h8000_0200; h_data = H1; tick();
        h_addr = 32'h0000_0310; h_data = H2; tick();
        chk("fill3_ready", h_ready, 1);
        h_addr = 32'h8000_0FF0; h_data = H3; tick();
        chk("fill4_ready", h_ready, 0);
        chk("fill4_idle",  idle, 0);
        h_addr = 32'h0000_0500; h_data = H4; tick();
        chk("fill5_ready", h_ready, 0);
        chk("fill5_we0",   we0, 1);
        chk("fill5_addr0", addr0, 1);
        chk("fill5_wdata", wdata, D_C);
        chk("fill5_hold",  hold_req, 0);
        h_valid = 1'b0;

        // ---- drain in FIFO order
        core_we = 1'b0;
        tick();
        chk("drain0_we0",   we0, 1);
        chk("drain0_addr0", addr0, 16);
        chk("drain0_wdata", wdata, H0);
        chk("drain0_ready", h_ready, 1);
        tick();
        chk("drain1_we1",   we1, 1);
        chk("drain1_addr1", addr1, 32);
        chk("drain1_wdata", wdata, H1);
        tick();
        chk("drain2_we0",   we0, 1);
        chk("drain2_addr0", addr0, 49);
        chk("drain2_wdata", wdata, H2);
        chk("drain2_idle",  idle, 0);
        tick();
        chk("drain3_we1",   we1, 1);
        chk("drain3_addr1", addr1, 255);
        chk("drain3_wdata", wdata, H3);
        chk("drain3_idle",  idle, 1);
        tick();
        chk("drained_we0",  we0, 0);
        chk("drained_we1",  we1, 0);
        chk("drained_idle", idle, 1);

        // ---- starvation: one host entry behind continuous core writes
        core_we = 1'b1; core_addr = 32'h0000_0020; core_data = D_D;
        h_valid = 1'b1; h_addr = 32'h8000_0040; h_data = H5;
        tick();
        h_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("starve15_hold", hold_req, 0);
        tick();
        chk("starve16_hold", hold_req, 0);
        tick();
        chk("starve17_hold", hold_req, 1);
        chk("starve17_wdata", wdata, D_D);
        chk("starve17_idle", idle, 0);
        core_we = 1'b0; hold_ack = 1'b1;
        tick();
        chk("hold_pop_we1",   we1, 1);
        chk("hold_pop_addr1", addr1, 4);
        chk("hold_pop_wdata", wdata, H5);
        chk("hold_pop_hold",  hold_req, 1);
        tick();
        chk("hold_rel_hold", hold_req, 0);
        chk("hold_rel_we1",  we1, 0);
        chk("hold_rel_idle", idle, 1);
        chk("hold_rel_err",  err, 0);

        // ---- violation: core writes while hold is acknowledged
        core_we = 1'b1; core_addr = 32'h0000_0050; core_data = D_E;
        tick();
        chk("viol_we0",   we0, 1);
        chk("viol_addr0", addr0, 5);
        chk("viol_wdata", wdata, D_E);
        chk("viol_err",   err, 1);
        core_we = 1'b0; hold_ack = 1'b0;
        tick(); tick();
        chk("viol_sticky", err, 1);

        // ---- reset while draining three queued entries
        core_we = 1'b1; core_addr = 32'h0000_0060; core_data = D_A;
        h_valid = 1'b1;
        h_addr = 32'h0000_0700; h_data = H0; tick();
        h_addr = 32'h0000_0710; h_data = H1; tick();
        h_addr = 32'h0000_0720; h_data = H2; tick();
        chk("pre_rst_idle", idle, 0);
        h_valid = 1'b0; core_we = 1'b0;
        tick();
        chk("mid_drain_we0", we0, 1);
        chk("mid_drain_addr0", addr0, 16'h70);
        rst_n = 1'b0;
        tick();
        chk("mrst_we0",   we0, 0);
        chk("mrst_ready", h_ready, 1);
        chk("mrst_err",   err, 0);
        chk("mrst_idle",  idle, 1);
        rst_n = 1'b1;
        tick();
        chk("after_we0",   we0, 0);
        chk("after_we1",   we1, 0);
        chk("after_idle",  idle, 1);
        chk("after_ready", h_ready, 1);
        tick();
        chk("after2_we0", we0, 0);
        chk("after2_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_wr_arbiter.md
Name: dram_wr_arbiter

Overview:
- Shares the B (write) ports of the two accelerator data RAMs (ram0: 14-bit word address; ram1: 17-bit word address) between two writers:
  - the core writeback path (we / addr_z / Z from the controller and datapath);
  - a host preload interface with a valid/ready handshake.
- The core has fixed priority and is never stalled by this block. Host writes wait in a small FIFO.
- A starvation counter raises a hold request to the controller, so host data cannot wait forever behind a long vector loop.
- Sits between mlacc_ctrl/mlacc_datapath and the blk_mem_gen B ports.

Parameters:
- DATA_W, 128, RAM word width
- AW0, 14, ram0 word-address width
- AW1, 17, ram1 word-address width
- FIFO_DEPTH, 4, host write FIFO entries (power of 2, ≥2)
- STARVE_LIMIT, 16, cycles the FIFO head may wait before a hold is requested (≥1)

Ports:
- in_clk  input  1  clock
- in_reset  input  1  reset, synchronous, active-low
- in_core_we  input  1  core write strobe
- in_core_addr  input  32  core byte address. Bit 31 = RAM select; bits [AWx+3:4] = word index.
- in_core_data  input  DATA_W  core write data
- in_h_valid  input  1  host write valid
- out_h_ready  output  1  host FIFO can accept
- in_h_addr  input  32  host byte address, same encoding as core
- in_h_data  input  DATA_W  host write data
- out_hold_req  output  1  request to the controller to suspend core writes
- in_hold_ack  input  1  controller guarantees in_core_we=0 while high
- out_we0  output  1  ram0 port-B write enable
- out_we1  output  1  ram1 port-B write enable
- out_addr0  output  AW0  ram0 port-B word address
- out_addr1  output  AW1  ram1 port-B word address
- out_wdata  output  DATA_W  shared port-B write data
- out_idle  output  1  FIFO empty and out_hold_req=0
- out_err  output  1  sticky: core wrote while in_hold_ack was high

Behaviour:
- Reset (in_reset=0 at a clock edge):
  - FIFO count and pointers = 0; wait counter = 0.
  - All outputs 0, except out_h_ready=1 and out_idle=1.
  - Reset mid-operation discards queued host writes; no RAM write occurs in the cycle after reset.
- Host push: in_h_valid & out_h_ready at the edge. out_h_ready = (count < FIFO_DEPTH), registered; there is no combinational path from pop.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Grant, evaluated each cycle:
  - G1: in_core_we=1 → core.
  - G2: else, FIFO non-empty → host head (pop).
  - G3: else → none.
- Port registers, loaded from the granted source (1-cycle latency to the RAM):
  - out_we0 = granted & ~addr[31]
  - out_we1 = granted & addr[31]
  - out_addr0 = addr[AW0+3:4]
  - out_addr1 = addr[AW1+3:4]
  - out_wdata = data
  - With no grant: out_we0/out_we1 = 0; address/data registers hold their previous values.
- Wait counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
- Hold FSM:
  - IDLE → REQ when the wait counter reaches STARVE_LIMIT. out_hold_req goes to 1 on the next edge.
  - REQ → IDLE on the edge after the first host pop.
  - While in REQ with in_hold_ack=1, G2 applies (the core is guaranteed silent).
- Violation: if in_core_we=1 while in_hold_ack=1, the core still wins and out_err is set. out_err clears only on reset.
- out_idle is registered: (next count == 0) & (next state == IDLE).
- An address whose word index exceeds AWx is truncated (upper bits ignored, no error).

Test Plan:
- Core-only writes: addr 0x0000_0040 data A, then 0x8000_0100 data B → next cycles out_we0=1/addr0=4/wdata=A, then out_we1=1/addr1=16/wdata=B.
- Host fill: 5 pushes with in_core_we=1 throughout → out_h_ready drops after the 4th accepted push; FIFO holds 4; no host write reaches the RAM.
- Drain: drop in_core_we → 4 host writes on 4 consecutive cycles in FIFO order; out_idle=1 one cycle after the last pop.
- Starvation: 1 host entry queued, core writes continuously → out_hold_req=1 after 16 wait cycles. Assert in_hold_ack with core silent → host write issues next cycle, then out_hold_req=0.
- Violation: in_hold_ack=1 and in_core_we=1 in the same cycle → core write issued, out_err=1 and stays 1 until reset.
- Reset mid-drain with 3 entries queued → after reset, FIFO empty, no writes, out_h_ready=1, out_err=0.
